// File: rtl/sha256_block_engine_pkg.sv
// Shared types, constants and SHA-256 bit functions for the block engine.
//   word_t    : 32-bit working word
//   work_t    : eight-word working/chaining state, field a (H0) in the MSBs
//   state_t   : engine FSM states {IDLE, ROUND, ADD}
//   K, IV     : FIPS 180-4 round constants and initial hash value
package sha256_block_engine_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BLK_W    = 512;
  localparam int unsigned DIG_W    = 256;
  localparam int unsigned N_ROUNDS = 64;
  localparam int unsigned N_SCHED  = 16;
  localparam int unsigned N_WORK   = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    ADD   = 2'd2
  } state_t;

  localparam word_t K [N_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [N_WORK] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam work_t IV_STATE = work_t'{IV[0], IV[1], IV[2], IV[3],
                                       IV[4], IV[5], IV[6], IV[7]};

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Word-wise modulo-2^32 add used for the end-of-block chain update.
  function automatic work_t add_work(input work_t x, input work_t y);
    work_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_block_engine_if.sv
// Block-in / digest-out bundle between the padder (master) and the engine (slave).
//   blk_valid/blk_ready : block handshake, accepted when both high on a rising edge
//   blk_data            : padded 512-bit block, W0 in [511:480]
//   blk_first/blk_last  : message start (reload IV) / message end (publish digest)
//   digest/digest_valid : final hash (H0 in [255:224]) and its valid flag
//   busy                : engine is processing an accepted block
interface sha256_block_engine_if;
  import sha256_block_engine_pkg::*;

  logic             blk_valid;
  logic             blk_ready;
  logic [BLK_W-1:0] blk_data;
  logic             blk_first;
  logic             blk_last;
  logic [DIG_W-1:0] digest;
  logic             digest_valid;
  logic             busy;

  modport master (
    output blk_valid, blk_data, blk_first, blk_last,
    input  blk_ready, digest, digest_valid, busy
  );

  modport slave (
    input  blk_valid, blk_data, blk_first, blk_last,
    output blk_ready, digest, digest_valid, busy
  );

endinterface

// File: rtl/sha256_block_engine_round.sv
// One combinational SHA-256 compression round.
//   st_i : working variables a..h before the round
//   k_i  : round constant K[t]
//   w_i  : schedule word W[t]
//   st_o : working variables after the round
module sha256_round
  import sha256_block_engine_pkg::*;
(
  input  work_t st_i,
  input  word_t k_i,
  input  word_t w_i,
  output work_t st_o
);

  word_t t1_c;
  word_t t2_c;

  always_comb begin
    t1_c   = st_i.h + big_sigma1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + k_i + w_i;
    t2_c   = big_sigma0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);
    st_o.a = t1_c + t2_c;
    st_o.b = st_i.a;
    st_o.c = st_i.b;
    st_o.d = st_i.c;
    st_o.e = st_i.d + t1_c;
    st_o.f = st_i.e;
    st_o.g = st_i.f;
    st_o.h = st_i.g;
  end

endmodule

// File: rtl/sha256_block_engine.sv
// Iterative SHA-256 compression engine for pre-padded multi-block messages.
// Runs ROUNDS_PER_CYCLE rounds per clock, chains H across blocks and publishes
// the digest after the block flagged last.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : block handshake and digest outputs (slave side)
module sha256_block_engine
  import sha256_block_engine_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
)
(
  input  logic                 clk,
  input  logic                 reset,
  sha256_block_engine_if.slave bus
);

  localparam int unsigned R      = ROUNDS_PER_CYCLE;
  localparam int unsigned EXT_N  = N_SCHED + R;
  localparam logic [5:0]  T_STEP = 6'(R);
  localparam logic [5:0]  T_LAST = 6'(N_ROUNDS - R);

  if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
    $error("sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t      state;
  logic [5:0]  t_q;
  word_t       win_q [N_SCHED];
  work_t       work_q;
  work_t       h_q;
  logic        last_q;

  word_t       ext_c [EXT_N];
  work_t       rnd_out_c;
  work_t       hsum_c;

  // Schedule window extended by R freshly expanded words; later words may
  // depend on words expanded earlier in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < N_SCHED; i++) begin
      ext_c[i] = win_q[i];
    end
    for (int unsigned i = N_SCHED; i < EXT_N; i++) begin
      ext_c[i] = small_sigma1(ext_c[i-2]) + ext_c[i-7] +
                 small_sigma0(ext_c[i-15]) + ext_c[i-16];
    end
  end

  // Chain of R rounds per clock, round j uses K[t+j] and W[t+j].
  for (genvar j = 0; j < int'(R); j++) begin : g_rnd
    work_t st_in;
    work_t st_out;
    if (j == 0) begin : g_head
      assign st_in = work_q;
    end else begin : g_link
      assign st_in = g_rnd[j-1].st_out;
    end
    sha256_round u_round (
      .st_i (st_in),
      .k_i  (K[6'(t_q + 6'(j))]),
      .w_i  (ext_c[j]),
      .st_o (st_out)
    );
  end

  assign rnd_out_c = g_rnd[R-1].st_out;
  assign hsum_c    = add_work(h_q, work_q);

  // FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      t_q              <= '0;
      work_q           <= '0;
      h_q              <= IV_STATE;
      last_q           <= 1'b0;
      for (int unsigned i = 0; i < N_SCHED; i++) begin
        win_q[i] <= '0;
      end
      bus.blk_ready    <= 1'b0;
      bus.digest       <= '0;
      bus.digest_valid <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.blk_ready <= 1'b1;
          if (bus.blk_valid && bus.blk_ready) begin
            for (int unsigned i = 0; i < N_SCHED; i++) begin
              win_q[i] <= bus.blk_data[BLK_W-1-WORD_W*i -: WORD_W];
            end
            // A first block starts from IV; otherwise continue the chain.
            work_q           <= bus.blk_first ? IV_STATE : h_q;
            if (bus.blk_first) begin
              h_q <= IV_STATE;
            end
            last_q           <= bus.blk_last;
            t_q              <= '0;
            bus.digest_valid <= 1'b0;
            bus.busy         <= 1'b1;
            bus.blk_ready    <= 1'b0;
            state            <= ROUND;
          end
        end
        ROUND: begin
          work_q <= rnd_out_c;
          for (int unsigned i = 0; i < N_SCHED; i++) begin
            win_q[i] <= ext_c[i+R];
          end
          t_q <= t_q + T_STEP;
          if (t_q == T_LAST) begin
            state <= ADD;
          end
        end
        ADD: begin
          h_q      <= hsum_c;
          bus.busy <= 1'b0;
          if (last_q) begin
            bus.digest       <= hsum_c;
            bus.digest_valid <= 1'b1;
          end
          bus.blk_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
